dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline's MEM stage and an external burst port (loader/DMA that fills or reads the data array). The CPU normally has priority. A DMA burst is granted when the CPU is idle, or forced after a starvation limit. While a burst holds the memory, the block stalls the pipeline. Sits between EXMEM outputs and data_memory, and feeds the pipeline's global stall together with the hazard unit.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_starve_counter.sv | 40 ++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMA_GRANT = 2'd1,
        DMA_BEAT  = 2'd2,
        DMA_DONE  = 2'd3
    } arb_state_e;

    localparam int BEAT_BYTES = 8;

    // A zero length still moves one beat; oversize requests are clipped to the burst limit.
    function automatic logic [3:0] norm_len(input logic [3:0] len, input int max_len);
        if (len == 4'd0) begin
            return 4'd1;
        end
        if (int'(len) > max_len) begin
            return 4'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive refused DMA cycles and flags when the refusal budget is used up.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(LIMIT - 1)) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a DMA burst port.
// The CPU has priority; a waiting burst is forced in after STARVE_LIMIT refusals.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LEN      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [3:0]        dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_wack,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              cpu_active;
    logic              starve_clr;
    logic              starve_inc;
    logic              starve_hit;
    logic [ADDR_W-1:0] beat_addr;

    assign cpu_active = cpu_re | cpu_we;
    assign starve_inc = (state_q == IDLE) && dma_req && cpu_active;
    assign starve_clr = !dma_req || (state_q == DMA_GRANT);
    assign beat_addr  = base_q + ADDR_W'(beat_cnt_q) * ADDR_W'(BEAT_BYTES);

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (starve_clr),
        .inc     (starve_inc),
        .at_limit(starve_hit)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        we_d       = we_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        dma_gnt    = 1'b0;
        dma_wack   = 1'b0;
        dma_done   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        case (state_q)
            IDLE: begin
                // The pass-through path is combinational, so gate it to keep outputs quiet in reset.
                if (reset) begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_we    = cpu_we;
                    mem_re    = cpu_re & ~cpu_we;
                    cpu_rdata = mem_rdata;
                    if (dma_req && (!cpu_active || starve_hit)) begin
                        state_d = DMA_GRANT;
                    end
                end
            end
            DMA_GRANT: begin
                dma_gnt    = 1'b1;
                cpu_stall  = 1'b1;
                base_d     = dma_addr;
                we_d       = dma_we;
                len_d      = norm_len(dma_len, MAX_LEN);
                beat_cnt_d = 4'd0;
                state_d    = DMA_BEAT;
            end
            DMA_BEAT: begin
                cpu_stall = 1'b1;
                mem_addr  = beat_addr;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = dma_wdata;
                    dma_wack  = 1'b1;
                end else begin
                    mem_re   = 1'b1;
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata;
                end
                beat_cnt_d = beat_cnt_q + 4'd1;
                if (beat_cnt_q == len_q - 4'd1) begin
                    state_d = DMA_DONE;
                end
            end
            DMA_DONE: begin
                dma_done  = 1'b1;
                cpu_stall = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            we_q       <= 1'b0;
            len_q      <= 4'd0;
            beat_cnt_q <= 4'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            we_q       <= we_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [63:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_len;
    logic        dma_gnt, dma_wack, dma_rvalid, dma_done;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    logic [63:0] mem_arr [64];
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .MAX_LEN(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_wack(dma_wack),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[8:3]];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[8:3]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = 4'd0; dma_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h18; cpu_wdata = 64'h1234;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h40; dma_len = 4'd3; dma_wdata = 64'h9;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_stall, mem_re, mem_we, dma_gnt, dma_wack, dma_rvalid, dma_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {cpu_stall, mem_re, mem_we, dma_gnt, dma_wack, dma_rvalid, dma_done});
        end
        checks++;
        if ((mem_addr | mem_wdata | cpu_rdata | dma_rdata) !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%0h wdata=%0h cpu_rdata=%0h dma_rdata=%0h required all 0",
                     mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: stall=%b gnt=%b required 0 0", cpu_stall, dma_gnt);
        end
    endtask

    task automatic test_cpu_only();
        tick();
        cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hDEAD;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 64'h10 || mem_wdata !== 64'hDEAD || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_store: we=%b addr=%0h wdata=%0h stall=%b required 1 10 dead 0",
                     mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 64'hDEAD || mem_re !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load: rdata=%0h re=%b stall=%b required dead 1 0", cpu_rdata, mem_re, cpu_stall);
        end
        tick();
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'hBEEF;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL cpu_write_wins: we=%b re=%b required 1 0", mem_we, mem_re);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_dma_write();
        logic [63:0] exp_addr[$];
        logic [63:0] exp_data[$];
        logic [63:0] ea, ed;
        logic [63:0] nextw;
        int stall_n;
        bit done_seen, gnt_now, wack_now;
        stall_n = 0; done_seen = 1'b0; nextw = 64'd2;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(64'(8 * i));
            exp_data.push_back(64'(i + 1));
        end
        tick();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h0; dma_len = 4'd4; dma_wdata = 64'd1;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            @(negedge clk);
            gnt_now = dma_gnt; wack_now = dma_wack;
            if (cpu_stall) stall_n++;
            if (dma_gnt) begin
                checks++;
                if (k != 1) begin errors++; $display("FAIL dmaw_gnt_cycle: got %0d required 1", k); end
            end
            if (mem_we) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL dmaw_extra_beat: addr=%0h required no write", mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    if (mem_addr !== ea || mem_wdata !== ed) begin
                        errors++;
                        $display("FAIL dmaw_beat: addr=%0h data=%0h required %0h %0h", mem_addr, mem_wdata, ea, ed);
                    end
                end
            end
            if (dma_done) begin
                done_seen = 1'b1;
                checks++;
                if (k != 6) begin errors++; $display("FAIL dmaw_done_cycle: got %0d required 6", k); end
            end
            tick();
            if (gnt_now) dma_req = 1'b0;
            if (wack_now) begin dma_wdata = nextw; nextw = nextw + 64'd1; end
        end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL dmaw_timeout: done=0 required 1"); end
        checks++;
        if (stall_n != 6) begin errors++; $display("FAIL dmaw_stall_len: got %0d required 6", stall_n); end
        checks++;
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL dmaw_missing: %0d beats left required 0", exp_addr.size());
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cpu_re = 1'b1; cpu_addr = 64'(8 * i);
            @(negedge clk);
            checks++;
            if (cpu_rdata !== 64'(i + 1) || cpu_stall !== 1'b0) begin
                errors++;
                $display("FAIL dmaw_readback[%0d]: rdata=%0h stall=%b required %0h 0", i, cpu_rdata, cpu_stall, i + 1);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_dma_read();
        logic [63:0] exp_data[$];
        logic [63:0] ed;
        int pulses;
        bit done_seen, gnt_now;
        pulses = 0; done_seen = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            cpu_we = 1'b1; cpu_addr = 64'(8 * i); cpu_wdata = 64'h100 + 64'(i);
            exp_data.push_back(64'h100 + 64'(i));
            tick();
        end
        idle_inputs();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h0; dma_len = 4'd8;
        for (int k = 0; k < 30 && !done_seen; k++) begin
            @(negedge clk);
            gnt_now = dma_gnt;
            if (dma_rvalid) begin
                pulses++;
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL dmar_extra_pulse: data=%0h required no pulse", dma_rdata);
                end else begin
                    ed = exp_data.pop_front();
                    if (dma_rdata !== ed) begin
                        errors++;
                        $display("FAIL dmar_beat: data=%0h required %0h", dma_rdata, ed);
                    end
                end
            end
            if (dma_done) begin
                done_seen = 1'b1;
                checks++;
                if (dma_rvalid !== 1'b1 || pulses != 8) begin
                    errors++;
                    $display("FAIL dmar_done_align: rvalid=%b pulses=%0d required 1 8", dma_rvalid, pulses);
                end
            end
            tick();
            if (gnt_now) dma_req = 1'b0;
        end
        checks++;
        if (!done_seen || exp_data.size() != 0) begin
            errors++;
            $display("FAIL dmar_complete: done=%b left=%0d required 1 0", done_seen, exp_data.size());
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        bit gnt_seen, done_seen;
        gnt_seen = 1'b0; done_seen = 1'b0;
        tick();
        for (int j = 0; j < 30 && !done_seen; j++) begin
            dma_req   = ((j < 3) || (j >= 4)) && !gnt_seen;
            dma_we    = 1'b0; dma_addr = 64'h100; dma_len = 4'd1;
            cpu_we    = (j < 8);
            cpu_re    = (j >= 8);
            cpu_addr  = (j < 8) ? 64'h100 + 64'(8 * j) : 64'h108;
            cpu_wdata = 64'hA0 + 64'(j);
            @(negedge clk);
            if (dma_gnt) begin
                gnt_seen = 1'b1;
                checks++;
                if (j != 8) begin errors++; $display("FAIL starve_gnt_cycle: got %0d required 8", j); end
            end
            if (j == 7) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 64'h138 || cpu_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_cpu_served: we=%b addr=%0h stall=%b required 1 138 0", mem_we, mem_addr, cpu_stall);
                end
            end
            if (dma_rvalid) begin
                checks++;
                if (dma_rdata !== 64'hA0) begin
                    errors++;
                    $display("FAIL starve_dma_data: got %0h required a0", dma_rdata);
                end
            end
            if (dma_done) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL starve_timeout: done=0 required 1"); end
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || cpu_rdata !== 64'hA1) begin
            errors++;
            $display("FAIL starve_held_load: stall=%b rdata=%0h required 0 a1", cpu_stall, cpu_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_boundary();
        logic [63:0] exp_addr[$];
        logic [63:0] exp_data[$];
        logic [63:0] bases[2];
        logic [63:0] firsts[2];
        logic [3:0]  lens[2];
        logic [63:0] ea, ed, nextw;
        int nbeats;
        bit done_seen, gnt_now, wack_now;
        bases[0] = 64'h40; bases[1] = 64'hFFFF_FFFF_FFFF_FFF8;
        firsts[0] = 64'h77; firsts[1] = 64'h55;
        lens[0] = 4'd0; lens[1] = 4'd2;
        for (int s = 0; s < 2; s++) begin
            nbeats = (s == 0) ? 1 : 2;
            done_seen = 1'b0;
            for (int b = 0; b < nbeats; b++) begin
                exp_addr.push_back(bases[s] + 64'(8 * b));
                exp_data.push_back(firsts[s] + 64'h11 * 64'(b));
            end
            nextw = firsts[s] + 64'h11;
            tick();
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = bases[s]; dma_len = lens[s]; dma_wdata = firsts[s];
            for (int k = 0; k < 20 && !done_seen; k++) begin
                @(negedge clk);
                gnt_now = dma_gnt; wack_now = dma_wack;
                if (mem_we) begin
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL bound_extra_beat[%0d]: addr=%0h required no write", s, mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        if (mem_addr !== ea || mem_wdata !== ed) begin
                            errors++;
                            $display("FAIL bound_beat[%0d]: addr=%0h data=%0h required %0h %0h", s, mem_addr, mem_wdata, ea, ed);
                        end
                    end
                end
                if (dma_done) begin
                    done_seen = 1'b1;
                    checks++;
                    if (k != nbeats + 2) begin
                        errors++;
                        $display("FAIL bound_done_cycle[%0d]: got %0d required %0d", s, k, nbeats + 2);
                    end
                end
                tick();
                if (gnt_now) dma_req = 1'b0;
                if (wack_now) begin dma_wdata = nextw; nextw = nextw + 64'h11; end
            end
            checks++;
            if (!done_seen || exp_addr.size() != 0) begin
                errors++;
                $display("FAIL bound_complete[%0d]: done=%b left=%0d required 1 0", s, done_seen, exp_addr.size());
            end
            idle_inputs();
        end
        cpu_re = 1'b1; cpu_addr = 64'h0;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 64'h66) begin errors++; $display("FAIL bound_wrap_readback: got %0h required 66", cpu_rdata); end
        tick();
        cpu_addr = 64'h40;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 64'h77) begin errors++; $display("FAIL bound_len0_readback: got %0h required 77", cpu_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        bit done_seen;
        done_seen = 1'b0;
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h0; dma_len = 4'd8;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            if (k == 2) dma_req = 1'b0;
            @(negedge clk);
            if (dma_done) done_seen = 1'b1;
        end
        checks++;
        if (cpu_stall !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 64'h10) begin
            errors++;
            $display("FAIL rst_beat3: stall=%b re=%b addr=%0h required 1 1 10", cpu_stall, mem_re, mem_addr);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_stall, mem_re, mem_we, dma_gnt, dma_wack, dma_rvalid, dma_done} !== 7'b0) begin
            errors++;
            $display("FAIL rst_async_ctrl: got %b required 0000000",
                     {cpu_stall, mem_re, mem_we, dma_gnt, dma_wack, dma_rvalid, dma_done});
        end
        checks++;
        if ((mem_addr | cpu_rdata | dma_rdata) !== 64'h0) begin
            errors++;
            $display("FAIL rst_async_data: addr=%0h cpu_rdata=%0h dma_rdata=%0h required 0",
                     mem_addr, cpu_rdata, dma_rdata);
        end
        repeat (3) begin
            @(negedge clk);
            if (dma_done) done_seen = 1'b1;
        end
        reset = 1'b1;
        cpu_re = 1'b1; cpu_addr = 64'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dma_done) done_seen = 1'b1;
        end
        checks++;
        if (cpu_stall !== 1'b0 || mem_re !== 1'b1 || cpu_rdata !== 64'h102) begin
            errors++;
            $display("FAIL rst_idle_after: stall=%b re=%b rdata=%0h required 0 1 102", cpu_stall, mem_re, cpu_rdata);
        end
        checks++;
        if (done_seen) begin errors++; $display("FAIL rst_no_done: done seen=1 required 0"); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_cpu_only();
        test_dma_write();
        test_dma_read();
        test_starvation();
        test_boundary();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
